// File: rtl/cond_pkg.sv
// Shared constants for the execute-stage condition unit.
// Condition codes, NZCV bit positions and the E/M control bundle.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic pcSrc;
    logic regWrite;
    logic memtoReg;
    logic memWrite;
  } em_ctrl_t;

endpackage

// File: rtl/condcheck.sv
// Combinational ARM condition-field evaluator.
// Compares a 4-bit condition code against the NZCV flags.
module condcheck
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v, ge;

  assign n  = Flags[FLAG_N];
  assign z  = Flags[FLAG_Z];
  assign c  = Flags[FLAG_C];
  assign v  = Flags[FLAG_V];
  assign ge = (n == v);

  // Condition table; NV never executes.
  always_comb begin
    CondEx = 1'b0;
    unique case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~z & ge;
      COND_LE: CondEx = z | ~ge;
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit_em.sv
// Execute-stage condition unit, NZCV register and E/M register.
// Gates side effects on condition/flush and forwards controls.
module cond_unit_em
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       PCSrcE,
  input  logic       RegWriteE,
  input  logic       MemtoRegE,
  input  logic       MemWriteE,
  input  logic       BranchE,
  input  logic [1:0] FlagWriteE,
  input  logic [3:0] CondE,
  input  logic [3:0] ALUFlags,
  input  logic       FlushE,
  output logic [3:0] Flags,
  output logic       CondExE,
  output logic       BranchTakenE,
  output logic       PCSrcM,
  output logic       RegWriteM,
  output logic       MemtoRegM,
  output logic       MemWriteM
);

  logic     kill;
  em_ctrl_t ctrlG;
  em_ctrl_t ctrlM;

  condcheck uCond (
    .Cond   (CondE),
    .Flags  (Flags),
    .CondEx (CondExE)
  );

  assign kill = FlushE | ~CondExE;

  assign BranchTakenE = BranchE & CondExE & ~FlushE;

  assign ctrlG.pcSrc    = PCSrcE & ~kill;
  assign ctrlG.regWrite = RegWriteE & ~kill;
  assign ctrlG.memtoReg = MemtoRegE & ~FlushE;
  assign ctrlG.memWrite = MemWriteE & ~kill;

  // NZCV register: two independently enabled halves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else if (!kill) begin
      if (FlagWriteE[1])
        Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (FlagWriteE[0])
        Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  // E/M register: memory never stalls, so load every edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ctrlM <= '0;
    else
      ctrlM <= ctrlG;
  end

  assign PCSrcM    = ctrlM.pcSrc;
  assign RegWriteM = ctrlM.regWrite;
  assign MemtoRegM = ctrlM.memtoReg;
  assign MemWriteM = ctrlM.memWrite;

endmodule
